multi_alarm_ctrl: RTL and testbench

// Parametrised alarm bank for the digital clock: NUM_ALARMS independent BCD alarms.

---
 rtl/multi_alarm_ctrl_if.sv | 25 ++
 rtl/multi_alarm_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_alarm_ctrl_if.sv
// User-interface bus between the alarm-setting front end and the alarm bank:
// button pulses and selection in, selected alarm time and edit cursor out.
interface multi_alarm_ctrl_if;
    logic [4:0]  btn;
    logic        edit_en;
    logic [2:0]  sel_alarm;
    logic [19:0] sel_time;
    logic [2:0]  edit_digit;

    modport master (
        output btn,
        output edit_en,
        output sel_alarm,
        input  sel_time,
        input  edit_digit
    );

    modport slave (
        input  btn,
        input  edit_en,
        input  sel_alarm,
        output sel_time,
        output edit_digit
    );
endinterface

// File: rtl/multi_alarm_ctrl.sv
// Bank of NUM_ALARMS BCD alarms with digit editing, arming, ring timeout and snooze.
// Per-alarm states:
//   DISARMED | alarm ignored
//   ARMED    | waiting for cur_time to equal the stored time
//   RINGING  | alarm active, counting towards RING_SEC auto-stop
//   SNOOZED  | silenced, counting towards SNOOZE_SEC before ringing again
module multi_alarm_ctrl #(
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic                  clk_sys,
    input  logic                  rstn,
    input  logic                  tick_1hz,
    input  logic [19:0]           cur_time,
    multi_alarm_ctrl_if.slave     ui,
    output logic [NUM_ALARMS-1:0] armed,
    output logic                  ringing,
    output logic [2:0]            ring_id
);

    typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZED} alarm_state_t;

    localparam logic [4:0] BTN_UP    = 5'b10000;
    localparam logic [4:0] BTN_LEFT  = 5'b01000;
    localparam logic [4:0] BTN_MID   = 5'b00100;
    localparam logic [4:0] BTN_DOWN  = 5'b00010;
    localparam logic [4:0] BTN_RIGHT = 5'b00001;

    localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
    localparam logic [3:0] NUM_ALARMS4 = 4'(NUM_ALARMS);

    alarm_state_t           state_q [NUM_ALARMS];
    alarm_state_t           state_d [NUM_ALARMS];
    logic [8:0]             cnt_q   [NUM_ALARMS];
    logic [8:0]             cnt_d   [NUM_ALARMS];
    logic [19:0]            time_q  [NUM_ALARMS];
    logic [19:0]            time_d  [NUM_ALARMS];
    logic [2:0]             digit_q;
    logic [2:0]             digit_d;
    logic                   tick_dly;
    logic                   edit_ok;
    logic                   ringing_d;
    logic [2:0]             ring_id_d;
    logic [NUM_ALARMS-1:0]  armed_d;
    logic [19:0]            sel_time_c;

    function automatic logic [3:0] wrap_step(input logic [3:0] v, input logic [3:0] top,
                                             input logic up);
        if (up)
            return (v >= top) ? 4'd0 : v + 4'd1;
        return (v == 4'd0) ? top : v - 4'd1;
    endfunction

    // One UP/DOWN step on the digit under the cursor, keeping hh within 00..23.
    function automatic logic [19:0] edit_time(input logic [19:0] t, input logic [2:0] digit,
                                              input logic up);
        logic [1:0] hh_h;
        logic [3:0] hh_l;
        logic [2:0] mm_h;
        logic [3:0] mm_l;
        logic [2:0] ss_h;
        logic [3:0] ss_l;
        logic [3:0] tmp;
        hh_h = t[19:18];
        hh_l = t[17:14];
        mm_h = t[13:11];
        mm_l = t[10:7];
        ss_h = t[6:4];
        ss_l = t[3:0];
        tmp  = 4'd0;
        case (digit)
            3'd0: ss_l = wrap_step(ss_l, 4'd9, up);
            3'd1: begin
                tmp  = wrap_step({1'b0, ss_h}, 4'd5, up);
                ss_h = tmp[2:0];
            end
            3'd2: mm_l = wrap_step(mm_l, 4'd9, up);
            3'd3: begin
                tmp  = wrap_step({1'b0, mm_h}, 4'd5, up);
                mm_h = tmp[2:0];
            end
            3'd4: hh_l = wrap_step(hh_l, (hh_h == 2'd2) ? 4'd3 : 4'd9, up);
            3'd5: begin
                if (up) begin
                    case (hh_h)
                        2'd0:    hh_h = 2'd1;
                        2'd1:    hh_h = (hh_l > 4'd3) ? 2'd0 : 2'd2;
                        default: hh_h = 2'd0;
                    endcase
                end else begin
                    case (hh_h)
                        2'd0:    hh_h = (hh_l > 4'd3) ? 2'd1 : 2'd2;
                        2'd1:    hh_h = 2'd0;
                        default: hh_h = 2'd1;
                    endcase
                end
            end
            default: ;
        endcase
        return {hh_h, hh_l, mm_h, mm_l, ss_h, ss_l};
    endfunction

    always_comb begin
        edit_ok = !ringing && ui.edit_en && ({1'b0, ui.sel_alarm} < NUM_ALARMS4);

        digit_d = digit_q;
        if (!ui.edit_en) begin
            digit_d = 3'd0;
        end else if (edit_ok) begin
            if (ui.btn == BTN_LEFT)
                digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
            else if (ui.btn == BTN_RIGHT)
                digit_d = (digit_q == 3'd0) ? 3'd5 : digit_q - 3'd1;
        end

        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            time_d[i]  = time_q[i];

            if (tick_1hz) begin
                if (state_q[i] == RINGING) begin
                    if (cnt_q[i] == RING_LAST) begin
                        state_d[i] = ARMED;
                        cnt_d[i]   = 9'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 9'd1;
                    end
                end else if (state_q[i] == SNOOZED) begin
                    if (cnt_q[i] == SNOOZE_LAST) begin
                        state_d[i] = RINGING;
                        cnt_d[i]   = 9'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 9'd1;
                    end
                end
            end

            if (ringing && ring_id == 3'(i)) begin
                if (ui.btn == BTN_MID) begin
                    state_d[i] = ARMED;
                    cnt_d[i]   = 9'd0;
                end else if (ui.btn == BTN_DOWN) begin
                    state_d[i] = SNOOZED;
                    cnt_d[i]   = 9'd0;
                end
            end else if (edit_ok && ui.sel_alarm == 3'(i)) begin
                if (ui.btn == BTN_MID) begin
                    state_d[i] = (state_q[i] == DISARMED) ? ARMED : DISARMED;
                    cnt_d[i]   = 9'd0;
                end else if (ui.btn == BTN_UP || ui.btn == BTN_DOWN) begin
                    time_d[i] = edit_time(time_q[i], digit_q, ui.btn == BTN_UP);
                end
            end

            // Match looks at the pre-edit state and time, so it overrides any button result.
            if (state_q[i] == ARMED && tick_dly && cur_time == time_q[i]) begin
                state_d[i] = RINGING;
                cnt_d[i]   = 9'd0;
            end
        end

        ringing_d = 1'b0;
        ring_id_d = 3'd0;
        armed_d   = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            armed_d[i] = (state_d[i] != DISARMED);
            if (state_d[i] == RINGING) begin
                ringing_d = 1'b1;
                ring_id_d = 3'(i);
            end
        end
    end

    always_comb begin
        sel_time_c = 20'h0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (ui.sel_alarm == 3'(i))
                sel_time_c = time_q[i];
        end
    end

    assign ui.sel_time   = sel_time_c;
    assign ui.edit_digit = digit_q;

    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            tick_dly <= 1'b0;
            digit_q  <= 3'd0;
            armed    <= '0;
            ringing  <= 1'b0;
            ring_id  <= 3'd0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= DISARMED;
                cnt_q[i]   <= 9'd0;
                time_q[i]  <= 20'h0;
            end
        end else begin
            tick_dly <= tick_1hz;
            digit_q  <= digit_d;
            armed    <= armed_d;
            ringing  <= ringing_d;
            ring_id  <= ring_id_d;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                time_q[i]  <= time_d[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: edit table, ring/snooze/multi-alarm/reset sequences,
// then random traffic checked every cycle against a digit/seconds-level model.
module tb_multi_alarm_ctrl;
    localparam int N    = 4;
    localparam int RING = 60;
    localparam int SNZ  = 300;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b10000;
    localparam logic [4:0] B_LEFT  = 5'b01000;
    localparam logic [4:0] B_MID   = 5'b00100;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    localparam int M_DIS  = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic          clk_sys  = 1'b0;
    logic          rstn     = 1'b0;
    logic          tick_1hz = 1'b0;
    logic [19:0]   cur_time = 20'h0;
    logic [N-1:0]  armed;
    logic          ringing;
    logic [2:0]    ring_id;

    multi_alarm_ctrl_if ui();

    multi_alarm_ctrl #(.NUM_ALARMS(N), .RING_SEC(RING), .SNOOZE_SEC(SNZ)) dut (
        .clk_sys (clk_sys),
        .rstn    (rstn),
        .tick_1hz(tick_1hz),
        .cur_time(cur_time),
        .ui      (ui.slave),
        .armed   (armed),
        .ringing (ringing),
        .ring_id (ring_id)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: digits per alarm, state code, ticks remaining in the current phase.
    int m_dig [N][6];
    int m_st  [N];
    int m_rem [N];
    int m_ed;
    int m_tickp;

    typedef struct {
        logic [4:0]  btn;
        logic        en;
        logic [2:0]  sel;
        logic [19:0] t;
        logic [2:0]  d;
        logic [3:0]  arm;
    } vec_t;

    vec_t tbl [28];

    function automatic logic [19:0] pack6(input int d0, input int d1, input int d2,
                                          input int d3, input int d4, input int d5);
        return {2'(d5), 4'(d4), 3'(d3), 4'(d2), 3'(d1), 4'(d0)};
    endfunction

    function automatic logic [19:0] bcd(input int s);
        int h, m, ss;
        h  = (s / 3600) % 24;
        m  = (s / 60) % 60;
        ss = s % 60;
        return pack6(ss % 10, ss / 10, m % 10, m / 10, h % 10, h / 10);
    endfunction

    function automatic logic [19:0] m_time(input int a);
        return pack6(m_dig[a][0], m_dig[a][1], m_dig[a][2], m_dig[a][3], m_dig[a][4], m_dig[a][5]);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < N; a++) begin
            for (int d = 0; d < 6; d++) m_dig[a][d] = 0;
            m_st[a]  = M_DIS;
            m_rem[a] = 0;
        end
        m_ed    = 0;
        m_tickp = 0;
    endtask

    task automatic model_edit(input int a, input int d, input bit up);
        int v, lim;
        v = m_dig[a][d];
        case (d)
            0, 2: v = up ? (v + 1) % 10 : (v + 9) % 10;
            1, 3: v = up ? (v + 1) % 6 : (v + 5) % 6;
            4: begin
                lim = (m_dig[a][5] == 2) ? 4 : 10;
                v = up ? (v + 1) % lim : (v + lim - 1) % lim;
            end
            default: begin
                v = up ? (v + 1) % 3 : (v + 2) % 3;
                if (v == 2 && m_dig[a][4] > 3) v = up ? 0 : 1;
            end
        endcase
        m_dig[a][d] = v;
    endtask

    task automatic model_step();
        int          rnow, rid, sel;
        bit          edit;
        int          pst [N];
        logic [19:0] ptime [N];
        rnow = 0;
        rid  = 0;
        for (int a = N - 1; a >= 0; a--)
            if (m_st[a] == M_RING) begin rnow = 1; rid = a; end
        sel  = int'(ui.sel_alarm);
        edit = (rnow == 0) && ui.edit_en && (sel < N);
        for (int a = 0; a < N; a++) begin
            pst[a]   = m_st[a];
            ptime[a] = m_time(a);
        end
        for (int a = 0; a < N; a++) begin
            if (tick_1hz && m_st[a] == M_RING) begin
                m_rem[a]--;
                if (m_rem[a] == 0) m_st[a] = M_ARM;
            end else if (tick_1hz && m_st[a] == M_SNZ) begin
                m_rem[a]--;
                if (m_rem[a] == 0) begin m_st[a] = M_RING; m_rem[a] = RING; end
            end
            if (rnow == 1 && a == rid) begin
                if (ui.btn == B_MID) m_st[a] = M_ARM;
                else if (ui.btn == B_DOWN) begin m_st[a] = M_SNZ; m_rem[a] = SNZ; end
            end else if (edit && a == sel) begin
                if (ui.btn == B_MID) m_st[a] = (pst[a] == M_DIS) ? M_ARM : M_DIS;
                else if (ui.btn == B_UP) model_edit(a, m_ed, 1'b1);
                else if (ui.btn == B_DOWN) model_edit(a, m_ed, 1'b0);
            end
            if (pst[a] == M_ARM && m_tickp == 1 && cur_time == ptime[a]) begin
                m_st[a]  = M_RING;
                m_rem[a] = RING;
            end
        end
        if (!ui.edit_en) m_ed = 0;
        else if (edit && ui.btn == B_LEFT) m_ed = (m_ed + 1) % 6;
        else if (edit && ui.btn == B_RIGHT) m_ed = (m_ed + 5) % 6;
        m_tickp = tick_1hz ? 1 : 0;
    endtask

    task automatic compare_model();
        logic [N-1:0] e_arm;
        logic         e_ring;
        logic [2:0]   e_id;
        logic [19:0]  e_sel;
        int           s;
        e_arm  = '0;
        e_ring = 1'b0;
        e_id   = 3'd0;
        for (int a = N - 1; a >= 0; a--) begin
            e_arm[a] = (m_st[a] != M_DIS);
            if (m_st[a] == M_RING) begin e_ring = 1'b1; e_id = 3'(a); end
        end
        s     = int'(ui.sel_alarm);
        e_sel = (s < N) ? m_time(s) : 20'h0;
        n_vec++;
        if (armed !== e_arm || ringing !== e_ring || ring_id !== e_id ||
            ui.sel_time !== e_sel || ui.edit_digit !== 3'(m_ed)) begin
            n_err++;
            $display("FAIL model_cycle t=%0t got arm=%b ring=%b id=%0d sel_time=%h digit=%0d want arm=%b ring=%b id=%0d sel_time=%h digit=%0d",
                     $time, armed, ringing, ring_id, ui.sel_time, ui.edit_digit,
                     e_arm, e_ring, e_id, e_sel, m_ed);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic press(input logic [4:0] b);
        ui.btn = b;
        step();
        ui.btn = B_NONE;
    endtask

    task automatic tick_at(input logic [19:0] t);
        tick_1hz = 1'b1;
        cur_time = t;
        step();
        tick_1hz = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{B_UP,    1'b1, 3'd0, 20'h00001, 3'd0, 4'b0000};
        tbl[1]  = '{B_UP,    1'b1, 3'd0, 20'h00002, 3'd0, 4'b0000};
        tbl[2]  = '{B_UP,    1'b1, 3'd0, 20'h00003, 3'd0, 4'b0000};
        tbl[3]  = '{B_LEFT,  1'b1, 3'd0, 20'h00003, 3'd1, 4'b0000};
        tbl[4]  = '{B_UP,    1'b1, 3'd0, 20'h00013, 3'd1, 4'b0000};
        tbl[5]  = '{B_UP,    1'b1, 3'd0, 20'h00023, 3'd1, 4'b0000};
        tbl[6]  = '{B_MID,   1'b1, 3'd0, 20'h00023, 3'd1, 4'b0001};
        tbl[7]  = '{B_NONE,  1'b1, 3'd2, 20'h00000, 3'd1, 4'b0001};
        tbl[8]  = '{B_RIGHT, 1'b1, 3'd2, 20'h00000, 3'd0, 4'b0001};
        tbl[9]  = '{B_RIGHT, 1'b1, 3'd2, 20'h00000, 3'd5, 4'b0001};
        tbl[10] = '{B_DOWN,  1'b1, 3'd2, 20'h80000, 3'd5, 4'b0001};
        tbl[11] = '{B_RIGHT, 1'b1, 3'd2, 20'h80000, 3'd4, 4'b0001};
        tbl[12] = '{B_UP,    1'b1, 3'd2, 20'h84000, 3'd4, 4'b0001};
        tbl[13] = '{B_UP,    1'b1, 3'd2, 20'h88000, 3'd4, 4'b0001};
        tbl[14] = '{B_UP,    1'b1, 3'd2, 20'h8C000, 3'd4, 4'b0001};
        tbl[15] = '{B_UP,    1'b1, 3'd2, 20'h80000, 3'd4, 4'b0001};
        tbl[16] = '{B_DOWN,  1'b1, 3'd2, 20'h8C000, 3'd4, 4'b0001};
        tbl[17] = '{B_LEFT,  1'b1, 3'd2, 20'h8C000, 3'd5, 4'b0001};
        tbl[18] = '{B_DOWN,  1'b1, 3'd2, 20'h4C000, 3'd5, 4'b0001};
        tbl[19] = '{B_RIGHT, 1'b1, 3'd2, 20'h4C000, 3'd4, 4'b0001};
        tbl[20] = '{B_UP,    1'b1, 3'd2, 20'h50000, 3'd4, 4'b0001};
        tbl[21] = '{B_UP,    1'b1, 3'd2, 20'h54000, 3'd4, 4'b0001};
        tbl[22] = '{B_LEFT,  1'b1, 3'd2, 20'h54000, 3'd5, 4'b0001};
        tbl[23] = '{B_UP,    1'b1, 3'd2, 20'h14000, 3'd5, 4'b0001};
        tbl[24] = '{B_DOWN,  1'b1, 3'd2, 20'h54000, 3'd5, 4'b0001};
        tbl[25] = '{B_UP,    1'b0, 3'd2, 20'h54000, 3'd0, 4'b0001};
        tbl[26] = '{B_UP,    1'b1, 3'd5, 20'h00000, 3'd0, 4'b0001};
        tbl[27] = '{B_RIGHT, 1'b1, 3'd5, 20'h00000, 3'd0, 4'b0001};

        ui.btn       = B_NONE;
        ui.edit_en   = 1'b0;
        ui.sel_alarm = 3'd0;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_sel_time", 32'(ui.sel_time), 32'h0);
        chk("rst_armed", 32'(armed), 32'h0);
        chk("rst_ringing", 32'(ringing), 32'h0);
        chk("rst_ring_id", 32'(ring_id), 32'h0);
        chk("rst_edit_digit", 32'(ui.edit_digit), 32'h0);
        @(negedge clk_sys);
        rstn = 1'b1;

        for (int i = 0; i < 28; i++) begin
            ui.btn       = tbl[i].btn;
            ui.edit_en   = tbl[i].en;
            ui.sel_alarm = tbl[i].sel;
            step();
            chk($sformatf("tbl%0d_sel_time", i), 32'(ui.sel_time), 32'(tbl[i].t));
            chk($sformatf("tbl%0d_edit_digit", i), 32'(ui.edit_digit), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_armed", i), 32'(armed), 32'(tbl[i].arm));
        end
        ui.btn       = B_NONE;
        ui.edit_en   = 1'b0;
        ui.sel_alarm = 3'd0;

        // Ring at 00:00:23, auto-stop after RING ticks.
        tick_at(bcd(22));
        idle(3);
        tick_at(bcd(23));
        chk("ring_one_cycle_after_tick", 32'(ringing), 32'h0);
        step();
        chk("ring_two_cycles_after_tick", 32'(ringing), 32'h1);
        chk("ring_id_alarm0", 32'(ring_id), 32'h0);
        for (int k = 1; k < RING; k++) begin
            idle(2);
            tick_at(bcd(23 + k));
        end
        chk("ring_before_timeout", 32'(ringing), 32'h1);
        idle(2);
        tick_at(bcd(23 + RING));
        chk("ring_timeout_stops", 32'(ringing), 32'h0);
        chk("ring_timeout_armed", 32'(armed), 32'h1);

        // Snooze, re-ring after SNZ ticks, dismiss.
        tick_at(bcd(23));
        step();
        chk("snz_ringing", 32'(ringing), 32'h1);
        press(B_DOWN);
        chk("snz_silenced", 32'(ringing), 32'h0);
        chk("snz_still_armed", 32'(armed), 32'h1);
        for (int k = 1; k < SNZ; k++) begin
            idle(2);
            tick_at(bcd(23 + k));
        end
        chk("snz_before_expiry", 32'(ringing), 32'h0);
        idle(2);
        tick_at(bcd(23 + SNZ));
        chk("snz_rerings", 32'(ringing), 32'h1);
        press(B_MID);
        chk("snz_dismiss", 32'(ringing), 32'h0);
        chk("snz_dismiss_armed", 32'(armed), 32'h1);

        // Alarms 1 and 3 at 12:00:00.
        ui.edit_en   = 1'b1;
        ui.sel_alarm = 3'd1;
        press(B_RIGHT); press(B_UP); press(B_RIGHT); press(B_UP); press(B_UP); press(B_MID);
        chk("alarm1_time", 32'(ui.sel_time), 32'(bcd(12 * 3600)));
        ui.sel_alarm = 3'd3;
        press(B_LEFT); press(B_UP); press(B_RIGHT); press(B_UP); press(B_UP); press(B_MID);
        chk("alarm3_time", 32'(ui.sel_time), 32'(bcd(12 * 3600)));
        ui.edit_en = 1'b0;
        step();
        chk("multi_armed", 32'(armed), 32'hB);
        tick_at(bcd(12 * 3600));
        step();
        chk("multi_ringing", 32'(ringing), 32'h1);
        chk("multi_ring_id_low", 32'(ring_id), 32'h1);
        press(B_MID);
        chk("multi_ring_id_next", 32'(ring_id), 32'h3);
        chk("multi_still_ringing", 32'(ringing), 32'h1);
        press(B_MID);
        chk("multi_all_dismissed", 32'(ringing), 32'h0);

        // Reset while ringing.
        idle(2);
        tick_at(bcd(12 * 3600));
        step();
        ui.sel_alarm = 3'd1;
        chk("prerst_ringing", 32'(ringing), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midring_rst_ringing", 32'(ringing), 32'h0);
        chk("midring_rst_armed", 32'(armed), 32'h0);
        chk("midring_rst_sel_time", 32'(ui.sel_time), 32'h0);
        chk("midring_rst_ring_id", 32'(ring_id), 32'h0);
        model_reset();
        @(negedge clk_sys);
        rstn = 1'b1;
        idle(3);
        tick_at(bcd(12 * 3600));
        idle(3);
        chk("no_ring_after_rst", 32'(ringing), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int r;
            if (!tick_1hz && $urandom_range(0, 2) == 0) begin
                tick_1hz = 1'b1;
                if ($urandom_range(0, 1) == 1) cur_time = m_time(int'($urandom_range(0, N - 1)));
                else cur_time = bcd(int'($urandom_range(0, 86399)));
            end else begin
                tick_1hz = 1'b0;
            end
            r = int'($urandom_range(0, 11));
            ui.btn = (r < 5) ? 5'(5'b00001 << r) : B_NONE;
            if ($urandom_range(0, 7) == 0) ui.edit_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) ui.sel_alarm = 3'($urandom_range(0, 7));
            step();
        end
        ui.btn   = B_NONE;
        tick_1hz = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
